// File: rtl/ps2_key_pkg.sv
// Shared constants for the PS/2 two-player key scheduler: scan codes,
// decoder state encoding, key-bit indices and the scan-code to key lookup.
package ps2_key_pkg;

  localparam logic [7:0] SC_EXT      = 8'hE0;
  localparam logic [7:0] SC_BRK      = 8'hF0;

  localparam logic [7:0] SC_P1_UP    = 8'h1D;
  localparam logic [7:0] SC_P1_DOWN  = 8'h1B;
  localparam logic [7:0] SC_P1_LEFT  = 8'h1C;
  localparam logic [7:0] SC_P1_RIGHT = 8'h23;
  localparam logic [7:0] SC_P1_SHOOT = 8'h3B;
  localparam logic [7:0] SC_P2_SHOOT = 8'h4C;
  localparam logic [7:0] SC_P2_UP    = 8'h75;
  localparam logic [7:0] SC_P2_DOWN  = 8'h72;
  localparam logic [7:0] SC_P2_LEFT  = 8'h6B;
  localparam logic [7:0] SC_P2_RIGHT = 8'h74;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_EXT     = 2'd1;
  localparam logic [1:0] ST_BRK     = 2'd2;
  localparam logic [1:0] ST_EXT_BRK = 2'd3;

  localparam logic [2:0] UP    = 3'd0;
  localparam logic [2:0] DOWN  = 3'd1;
  localparam logic [2:0] LEFT  = 3'd2;
  localparam logic [2:0] RIGHT = 3'd3;
  localparam logic [2:0] SHOOT = 3'd4;

  typedef struct packed {
    logic       hit;
    logic       player;
    logic [2:0] idx;
  } key_map_t;

  // Arrow codes only map when E0-prefixed; the bare codes are keypad keys.
  function automatic key_map_t key_lookup(input logic ext, input logic [7:0] code);
    key_map_t m;
    m = '0;
    if (ext) begin
      case (code)
        SC_P2_UP:    m = '{hit: 1'b1, player: 1'b1, idx: UP};
        SC_P2_DOWN:  m = '{hit: 1'b1, player: 1'b1, idx: DOWN};
        SC_P2_LEFT:  m = '{hit: 1'b1, player: 1'b1, idx: LEFT};
        SC_P2_RIGHT: m = '{hit: 1'b1, player: 1'b1, idx: RIGHT};
        default:     m = '0;
      endcase
    end else begin
      case (code)
        SC_P1_UP:    m = '{hit: 1'b1, player: 1'b0, idx: UP};
        SC_P1_DOWN:  m = '{hit: 1'b1, player: 1'b0, idx: DOWN};
        SC_P1_LEFT:  m = '{hit: 1'b1, player: 1'b0, idx: LEFT};
        SC_P1_RIGHT: m = '{hit: 1'b1, player: 1'b0, idx: RIGHT};
        SC_P1_SHOOT: m = '{hit: 1'b1, player: 1'b0, idx: SHOOT};
        SC_P2_SHOOT: m = '{hit: 1'b1, player: 1'b1, idx: SHOOT};
        default:     m = '0;
      endcase
    end
    return m;
  endfunction

endpackage

// File: rtl/shot_rr_arb.sv
// Round-robin shot arbiter: per-player cooldown counters and a req/ack
// handshake to the shared projectile resource.
module shot_rr_arb #(
  parameter logic [15:0] COOLDOWN = 16'd50000
) (
  input  logic       board_clk,
  input  logic       reset,
  input  logic [1:0] shoot,
  input  logic       spawn_ack,
  output logic       spawn_req,
  output logic       spawn_id
);

  logic [1:0][15:0] cnt;
  logic             prio;
  logic [1:0]       elig;
  logic             pick;

  always_comb begin
    elig[0] = shoot[0] && (cnt[0] == '0);
    elig[1] = shoot[1] && (cnt[1] == '0);
    pick    = (elig == 2'b11) ? prio : elig[1];
  end

  // The granted counter's COOLDOWN load overrides its decrement.
  always_ff @(posedge board_clk) begin
    if (reset) begin
      cnt       <= '0;
      prio      <= 1'b0;
      spawn_req <= 1'b0;
      spawn_id  <= 1'b0;
    end else begin
      if (cnt[0] != '0) cnt[0] <= cnt[0] - 16'd1;
      if (cnt[1] != '0) cnt[1] <= cnt[1] - 16'd1;
      if (spawn_req) begin
        if (spawn_ack) begin
          spawn_req     <= 1'b0;
          cnt[spawn_id] <= COOLDOWN;
          prio          <= ~spawn_id;
        end
      end else if (|elig) begin
        spawn_req <= 1'b1;
        spawn_id  <= pick;
      end
    end
  end

endmodule

// File: rtl/ps2_key_sched.sv
// PS/2 scan-code decoder holding two players' key state, feeding a shot arbiter.
// Optional prefix timeout: define PS2_SCHED_TIMEOUT_EN.
module ps2_key_sched #(
  parameter logic [15:0] COOLDOWN = 16'd50000,
  parameter logic [19:0] TIMEOUT  = 20'd500000
) (
  input  logic       board_clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [4:0] p1,
  output logic [4:0] p2,
  output logic       spawn_req,
  output logic       spawn_id,
  input  logic       spawn_ack,
  output logic       proto_err
);
  import ps2_key_pkg::*;

  logic [1:0] state;
  logic [1:0] state_d;
  logic       err_d;
  logic       upd;
  logic       make;
  logic       ext;
  logic       timeout_hit;
  key_map_t   map;
  logic [4:0] p1_d;
  logic [4:0] p2_d;

`ifdef PS2_SCHED_TIMEOUT_EN
  logic [19:0] timer;

  always_comb begin
    timeout_hit = (state != ST_IDLE) && !rx_valid &&
                  (({1'b0, timer} + 21'd1) >= {1'b0, TIMEOUT});
  end

  always_ff @(posedge board_clk) begin
    if (reset) begin
      timer <= '0;
    end else if (rx_valid || (state == ST_IDLE) || timeout_hit) begin
      timer <= '0;
    end else begin
      timer <= timer + 20'd1;
    end
  end
`else
  always_comb begin
    timeout_hit = 1'b0;
  end
`endif

  always_comb begin
    state_d = state;
    err_d   = 1'b0;
    upd     = 1'b0;
    make    = (state == ST_IDLE) || (state == ST_EXT);
    ext     = (state == ST_EXT) || (state == ST_EXT_BRK);
    if (rx_valid) begin
      if (rx_data == SC_EXT) begin
        if (state == ST_IDLE) begin
          state_d = ST_EXT;
        end else begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end else if (rx_data == SC_BRK) begin
        case (state)
          ST_IDLE: state_d = ST_BRK;
          ST_EXT:  state_d = ST_EXT_BRK;
          default: begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        endcase
      end else begin
        upd     = 1'b1;
        state_d = ST_IDLE;
      end
    end else if (timeout_hit) begin
      err_d   = 1'b1;
      state_d = ST_IDLE;
    end
  end

  always_comb begin
    map  = key_lookup(ext, rx_data);
    p1_d = p1;
    p2_d = p2;
    if (upd && map.hit) begin
      if (map.player) p2_d[map.idx] = make;
      else            p1_d[map.idx] = make;
    end
  end

  always_ff @(posedge board_clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      proto_err <= 1'b0;
      p1        <= '0;
      p2        <= '0;
    end else begin
      state     <= state_d;
      proto_err <= err_d;
      p1        <= p1_d;
      p2        <= p2_d;
    end
  end

  shot_rr_arb #(
    .COOLDOWN (COOLDOWN)
  ) u_arb (
    .board_clk (board_clk),
    .reset     (reset),
    .shoot     ({p2[SHOOT], p1[SHOOT]}),
    .spawn_ack (spawn_ack),
    .spawn_req (spawn_req),
    .spawn_id  (spawn_id)
  );

endmodule

// File: tb/tb_ps2_key_sched.sv
// Randomized and directed checks of ps2_key_sched against a behavioural model.
module tb_ps2_key_sched;

  localparam logic [15:0] CD  = 16'd4;
  localparam int          TMO = 8;

  logic       board_clk = 1'b0;
  logic       reset     = 1'b0;
  logic [7:0] rx_data   = 8'h00;
  logic       rx_valid  = 1'b0;
  logic       spawn_ack = 1'b0;
  logic [4:0] p1, p2;
  logic       spawn_req, spawn_id, proto_err;

  always #5 board_clk = ~board_clk;

  ps2_key_sched #(
    .COOLDOWN (CD),
    .TIMEOUT  (20'd8)
  ) dut (
    .board_clk (board_clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .p1        (p1),
    .p2        (p2),
    .spawn_req (spawn_req),
    .spawn_id  (spawn_id),
    .spawn_ack (spawn_ack),
    .proto_err (proto_err)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: key state as bit arrays, prefix as two flags.
  bit [4:0] m_p [2];
  bit       m_ext, m_brk, m_err, m_req;
  int       m_id, m_last, m_idle;
  int       m_cd [2];
  int       age;
  int       cyc;

  // Observed DUT handshake for grant bookkeeping.
  bit       obs_req, obs_id;
  int       g_id [$];
  int       g_cyc [$];

  task automatic apply_key(input bit ext, input bit make, input logic [7:0] d);
    int pl, b;
    pl = -1; b = -1;
    if (ext) begin
      case (d)
        8'h75: begin pl = 1; b = 0; end
        8'h72: begin pl = 1; b = 1; end
        8'h6B: begin pl = 1; b = 2; end
        8'h74: begin pl = 1; b = 3; end
        default: ;
      endcase
    end else begin
      case (d)
        8'h1D: begin pl = 0; b = 0; end
        8'h1B: begin pl = 0; b = 1; end
        8'h1C: begin pl = 0; b = 2; end
        8'h23: begin pl = 0; b = 3; end
        8'h3B: begin pl = 0; b = 4; end
        8'h4C: begin pl = 1; b = 4; end
        default: ;
      endcase
    end
    if (pl >= 0) m_p[pl][b] = make;
  endtask

  task automatic model_edge(input bit v, input logic [7:0] d, input bit a, input bit r);
    bit e0, e1;
    if (r) begin
      m_p[0] = '0; m_p[1] = '0;
      m_ext = 0; m_brk = 0; m_err = 0; m_req = 0;
      m_id = 0; m_last = 1; m_idle = 0;
      m_cd[0] = 0; m_cd[1] = 0;
    end else begin
      e0 = m_p[0][4] && (m_cd[0] == 0);
      e1 = m_p[1][4] && (m_cd[1] == 0);
      for (int i = 0; i < 2; i++) if (m_cd[i] > 0) m_cd[i]--;
      if (m_req) begin
        if (a) begin
          m_cd[m_id] = int'(CD);
          m_last = m_id;
          m_req = 0;
        end
      end else if (e0 || e1) begin
        m_req = 1;
        if (e0 && e1) m_id = (m_last == 0) ? 1 : 0;
        else m_id = e1 ? 1 : 0;
      end
      m_err = 0;
      if (v) begin
        m_idle = 0;
        if (d == 8'hE0) begin
          if (m_ext || m_brk) begin m_err = 1; m_ext = 0; m_brk = 0; end
          else m_ext = 1;
        end else if (d == 8'hF0) begin
          if (m_brk) begin m_err = 1; m_ext = 0; m_brk = 0; end
          else m_brk = 1;
        end else begin
          apply_key(m_ext, !m_brk, d);
          m_ext = 0; m_brk = 0;
        end
      end
`ifdef PS2_SCHED_TIMEOUT_EN
      else if (m_ext || m_brk) begin
        m_idle++;
        if (m_idle >= TMO) begin
          m_err = 1; m_ext = 0; m_brk = 0; m_idle = 0;
        end
      end
`endif
    end
  endtask

  task automatic step(input bit v, input logic [7:0] d, input bit a, input bit r);
    reset = r; rx_valid = v; rx_data = d; spawn_ack = a;
    if (a && obs_req && !r) begin
      g_id.push_back(int'(obs_id));
      g_cyc.push_back(cyc);
    end
    @(posedge board_clk);
    model_edge(v, d, a, r);
    cyc++;
    #1;
    check("p1", {11'd0, p1}, {11'd0, m_p[0]});
    check("p2", {11'd0, p2}, {11'd0, m_p[1]});
    check("spawn_req", {15'd0, spawn_req}, {15'd0, m_req});
    check("spawn_id", {15'd0, spawn_id}, 16'(m_id));
    check("proto_err", {15'd0, proto_err}, {15'd0, m_err});
    obs_req = spawn_req; obs_id = spawn_id;
    age = m_req ? age + 1 : 0;
    reset = 1'b0; rx_valid = 1'b0; spawn_ack = 1'b0;
  endtask

  task automatic send(input logic [7:0] d);
    step(1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic wait_req(input string tag);
    for (int k = 0; k < 12 && !m_req; k++) idle(1);
    check(tag, {15'd0, spawn_req}, 16'd1);
  endtask

  logic [7:0] pool [13];
  int         n_after;

  initial begin
    pool = '{8'hE0, 8'hF0, 8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h3B,
             8'h4C, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h5A};
    cyc = 0; age = 0; obs_req = 0; obs_id = 0;

    do_reset();
    check("rst_p1", {11'd0, p1}, 16'd0);
    check("rst_req", {15'd0, spawn_req}, 16'd0);

    // P1 up make, then break
    send(8'h1D);
    check("p1_up_make", {15'd0, p1[0]}, 16'd1);
    idle(2);
    send(8'hF0); send(8'h1D);
    check("p1_up_break", {15'd0, p1[0]}, 16'd0);

    // Extended vs keypad
    send(8'hE0); send(8'h75);
    check("p2_up_ext", {15'd0, p2[0]}, 16'd1);
    send(8'h75);
    check("keypad_ignored", {11'd0, p2}, 16'h0001);
    send(8'hE0); send(8'hF0); send(8'h75);
    check("p2_up_ext_break", {15'd0, p2[0]}, 16'd0);

    // Malformed prefix
    send(8'hE0); send(8'hE0);
    check("e0e0_err", {15'd0, proto_err}, 16'd1);
    idle(1);
    check("err_one_cycle", {15'd0, proto_err}, 16'd0);
    send(8'h1B);
    check("idle_after_err", {15'd0, p1[1]}, 16'd1);
    send(8'hF0); send(8'hF0); send(8'hF0); send(8'h1B);
    check("f0f0_recover", {15'd0, p1[1]}, 16'd0);

    // Round robin with cooldown, ack one cycle after each request
    do_reset();
    g_id.delete(); g_cyc.delete();
    send(8'h3B); send(8'h4C);
    repeat (40) step(1'b0, 8'h00, m_req && (age >= 2), 1'b0);
    check("rr_count", 16'(g_id.size() >= 4), 16'd1);
    if (g_id.size() >= 4) begin
      for (int i = 0; i < 4; i++) check("rr_seq", 16'(g_id[i]), 16'(i % 2));
    end
    for (int i = 0; i < g_id.size(); i++)
      for (int j = i + 1; j < g_id.size(); j++)
        if (g_id[j] == g_id[i]) begin
          check("cd_gap", 16'((g_cyc[j] - g_cyc[i]) >= 4), 16'd1);
          break;
        end

    // Request held through shoot release, no more P1 requests afterwards
    do_reset();
    send(8'h3B);
    wait_req("req_seen");
    send(8'hF0); idle(2); send(8'h3B); idle(3);
    check("req_held", {15'd0, spawn_req}, 16'd1);
    check("id_held", {15'd0, spawn_id}, 16'd0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    n_after = 0;
    repeat (20) begin
      step(1'b0, 8'h00, m_req, 1'b0);
      if (spawn_req) n_after++;
    end
    check("no_more_req", 16'(n_after), 16'd0);

    // Reset mid-request, also colliding with rx_valid and ack
    send(8'h4C);
    wait_req("req_seen2");
    step(1'b1, 8'h1D, 1'b1, 1'b1);
    check("rst_mid_req", {3'd0, p1, p2, spawn_req, spawn_id, proto_err}, 16'd0);

    // Prefix left open for eight idle cycles, then a bare code
    send(8'h1D);
    send(8'hF0);
    idle(8);
`ifdef PS2_SCHED_TIMEOUT_EN
    check("tmo_err", {15'd0, proto_err}, 16'd1);
    send(8'h1D);
    check("tmo_then_make", {15'd0, p1[0]}, 16'd1);
`else
    check("no_tmo_err", {15'd0, proto_err}, 16'd0);
    send(8'h1D);
    check("wait_then_break", {15'd0, p1[0]}, 16'd0);
`endif

    // Randomized traffic
    do_reset();
    repeat (3000) begin
      bit v, a, r;
      logic [7:0] d;
      v = ($urandom_range(0, 9) < 4);
      d = pool[$urandom_range(0, 12)];
      if (d == 8'h5A) d = 8'($urandom);
      a = ($urandom_range(0, 1) == 1);
      r = ($urandom_range(0, 399) == 0);
      step(v, d, a, r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/ps2_key_sched.md
PS2_KEY_SCHED -- requirements
Module: ps2_key_sched

Interface
REQ-001 SHALL have parameter COOLDOWN, default 16'd50000: cycles a player is blocked after a granted shot; 16 bits, 0 means no cooldown.
REQ-002 SHALL have parameter TIMEOUT, default 20'd500000: inter-byte prefix timeout in cycles; 20 bits; used only under PS2_SCHED_TIMEOUT_EN.
REQ-003 SHALL have port board_clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port rx_data, input, 8 bits: received PS/2 scan byte.
REQ-006 SHALL have port rx_valid, input, 1 bit: one-cycle strobe qualifying rx_data, synchronous to board_clk.
REQ-007 SHALL have ports p1 and p2, output, 5 bits each: held key state; bit0 up, bit1 down, bit2 left, bit3 right, bit4 shoot.
REQ-008 SHALL have port spawn_req, output, 1 bit: shot spawn request to the shared projectile resource.
REQ-009 SHALL have port spawn_id, output, 1 bit: requesting player, 0=P1, 1=P2.
REQ-010 SHALL have port spawn_ack, input, 1 bit: resource accepts the request this cycle.
REQ-011 SHALL have port proto_err, output, 1 bit: one-cycle pulse on a malformed prefix sequence.

Function
REQ-012 Decoder FSM SHALL have states IDLE, EXT, BRK, EXT_BRK and advance only on cycles with rx_valid=1.
REQ-013 Prefix transitions SHALL be: IDLE+E0 -> EXT; IDLE+F0 -> BRK; EXT+F0 -> EXT_BRK.
REQ-014 Any non-prefix byte SHALL complete a code and return the FSM to IDLE: make in IDLE/EXT, break in BRK/EXT_BRK; extended when reached via EXT.
REQ-015 Non-extended map SHALL be: 1D P1 up, 1B P1 down, 1C P1 left, 23 P1 right, 3B P1 shoot, 4C P2 shoot.
REQ-016 Extended map SHALL be: 75 P2 up, 72 P2 down, 6B P2 left, 74 P2 right; these bytes without E0 (keypad) SHALL be ignored.
REQ-017 A make code SHALL set its p-bit and a break code SHALL clear it; unmapped codes leave p1/p2 unchanged.
REQ-018 Latency SHALL be: byte strobed in cycle N -> p1/p2 updated at the edge ending cycle N (visible cycle N+1).
REQ-019 Malformed prefix (E0 in EXT/BRK/EXT_BRK, or F0 in BRK/EXT_BRK) SHALL pulse proto_err for one cycle and return the FSM to IDLE with no key update.
REQ-020 Each player SHALL have a 16-bit cooldown counter that decrements by 1 per cycle while nonzero and saturates at 0.
REQ-021 A player SHALL be eligible when its shoot bit=1 and its counter=0.
REQ-022 Arbitration SHALL be round-robin: with both eligible, the player not granted last wins; after reset P1 has priority.
REQ-023 Once asserted, spawn_req and spawn_id SHALL hold stable until spawn_ack=1, even if shoot is released meanwhile.
REQ-024 On the spawn_ack cycle, the granted player's counter SHALL load COOLDOWN, the RR pointer SHALL flip, and spawn_req SHALL drop for at least one cycle.
REQ-025 spawn_ack while spawn_req=0 SHALL be ignored.
REQ-026 A new rx_valid byte arriving while a spawn is pending SHALL be processed normally; the decoder and the arbiter are independent.

Reset
REQ-027 With reset=1 at an edge: p1=0, p2=0, spawn_req=0, spawn_id=0, proto_err=0, FSM=IDLE, both counters=0, RR pointer=P1.
REQ-028 Reset SHALL take priority over rx_valid and spawn_ack in the same cycle; a pending request is dropped.

Configuration
REQ-029 With PS2_SCHED_TIMEOUT_EN defined, a 20-bit timer SHALL reset on every rx_valid and count while FSM!=IDLE.
REQ-030 With PS2_SCHED_TIMEOUT_EN defined, reaching TIMEOUT SHALL return the FSM to IDLE and pulse proto_err.
REQ-031 Without PS2_SCHED_TIMEOUT_EN, the timer SHALL be absent and the FSM SHALL wait indefinitely in prefix states.

Structure
REQ-032 Package ps2_key_pkg SHALL hold: scan-code constants (E0, F0, the 10 key codes), decoder state encoding, and p-bit index constants (UP=0 ... SHOOT=4).
REQ-033 The cooldown counters, RR pointer and req/ack handshake SHALL live in sub-module shot_rr_arb; decoder and key state SHALL stay in ps2_key_sched.

Verification
REQ-034 Bytes 1D, then F0 1D -> p1[0]=1 the cycle after the first byte, 0 the cycle after the second 1D; proto_err stays 0.
REQ-035 E0 75 then 75 -> p2[0]=1 after E0 75 only; bare 75 changes nothing; E0 F0 75 -> p2[0]=0.
REQ-036 COOLDOWN=4, 3B and 4C held, ack 1 cycle after each req -> spawn_id sequence 0,1,0,1; each player's grants at least 4 cycles apart.
REQ-037 Req pending with spawn_ack=0 and F0 3B delivered -> spawn_req and spawn_id held until ack; no further P1 requests afterwards.
REQ-038 E0 E0 -> one proto_err pulse, FSM=IDLE; reset asserted mid-request -> all outputs 0 the next cycle.
REQ-039 With PS2_SCHED_TIMEOUT_EN and TIMEOUT=8, F0 then 8 idle cycles -> proto_err pulse; a following 1D is treated as a make.
